ctrl_clken: RTL and testbench



---
 rtl/ctrl_clken_pkg.sv | 34 +++
 rtl/ctrl_clken_if.sv | 37 +++
 rtl/ctrl_clken_div.sv | 55 +++++
 rtl/ctrl_clken.sv | 185 ++++++++++++++++++
 tb/tb_ctrl_clken.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ctrl_clken_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_clken_pkg
// Shared types and helpers for the ctrl_clken lock-qualified reset sequencer /
// clock-enable generator.
//   - state_t     : sequencer FSM state encoding
//   - f_scnt_w()  : width of the stable-lock counter for a given RST_CYCLES
//   - f_low_w()   : width of the lock-low filter counter for a given LOSS_CYCLES
// -----------------------------------------------------------------------------
package ctrl_clken_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    // The stable counter only has to reach RST_CYCLES-1, so clog2(RST_CYCLES)
    // bits suffice; one bit is the floor for the degenerate small settings.
    function automatic int f_scnt_w(input int rst_cycles);
        if (rst_cycles <= 2) begin
            return 1;
        end
        return $clog2(rst_cycles);
    endfunction

    // The low counter saturates at LOSS_CYCLES, so it must hold that value.
    function automatic int f_low_w(input int loss_cycles);
        if (loss_cycles <= 1) begin
            return 1;
        end
        return $clog2(loss_cycles + 1);
    endfunction

endpackage

// File: rtl/ctrl_clken_if.sv
// -----------------------------------------------------------------------------
// ctrl_clken_if
// Bundles the lock input, divide settings and sequencer outputs of ctrl_clken.
//   locked_in : PLL lock flag (asynchronous to clk)
//   div       : CH*CW packed divide values, channel n at [n*CW +: CW]
//   ce        : per-channel clock-enable pulses
//   rst_out   : synchronous active-high reset for downstream logic
//   ready     : high while the sequencer is in RUN
// Modports: master = the side supplying lock/divide (PLL wrapper / bench),
//           slave  = ctrl_clken itself.
// -----------------------------------------------------------------------------
interface ctrl_clken_if #(
    parameter int CH = 3,
    parameter int CW = 8
);
    logic               locked_in;
    logic [CH*CW-1:0]   div;
    logic [CH-1:0]      ce;
    logic               rst_out;
    logic               ready;

    modport master (
        output locked_in,
        output div,
        input  ce,
        input  rst_out,
        input  ready
    );

    modport slave (
        input  locked_in,
        input  div,
        output ce,
        output rst_out,
        output ready
    );
endinterface

// File: rtl/ctrl_clken_div.sv
// -----------------------------------------------------------------------------
// ctrl_clken_div
// One clock-enable divider channel. Produces a one-cycle pulse every dl+1
// cycles while the sequencer is in RUN; dl is reloaded from div only at a wrap,
// so a new divide value never truncates the period in progress.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   run  : high when the sequencer will be in RUN in the next cycle
//   div  : divide value for this channel
//   ce   : clock-enable pulse (decoded from registers only)
// -----------------------------------------------------------------------------
module ctrl_clken_div #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [CW-1:0] div,
    output logic          ce
);

    logic          r_run;   // registered run: high exactly during RUN cycles
    logic [CW-1:0] r_c;
    logic [CW-1:0] r_dl;

    // Outside RUN both registers sit at 0, so c==dl holds in the first RUN
    // cycle: every channel pulses there and the wrap in that cycle performs
    // the initial load of div. All channels therefore start phase-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= 1'b0;
            r_c   <= '0;
            r_dl  <= '0;
        end else begin
            r_run <= run;
            if (!run) begin
                // Cleared on the same edge that leaves RUN, so the counters
                // read 0 in every non-RUN cycle.
                r_c  <= '0;
                r_dl <= '0;
            end else if (r_run) begin
                if (r_c == r_dl) begin
                    r_c  <= '0;
                    r_dl <= div;
                end else begin
                    r_c  <= r_c + CW'(1);
                end
            end
        end
    end

    assign ce = r_run & (r_c == r_dl);

endmodule

// File: rtl/ctrl_clken.sv
// -----------------------------------------------------------------------------
// ctrl_clken
// Lock-qualified reset sequencer and multi-channel clock-enable generator.
// Holds rst_out high until the PLL lock flag has been stable for RST_CYCLES
// cycles, then runs CH phase-aligned clock-enable dividers.
// Parameters:
//   CH          : number of clock-enable channels (1..8)
//   CW          : divider width per channel
//   RST_CYCLES  : stable-lock cycles before reset release (>=1)
//   LOSS_CYCLES : consecutive low-lock cycles that count as loss (filter only)
// Ports:
//   clk    : system clock, the only clock
//   rst    : synchronous active-high reset
//   io_bus : ctrl_clken_if.slave (locked_in, div in; ce, rst_out, ready out)
// Build option:
//   CTRL_CLKEN_LOCK_FILTER_EN : when defined, short lock dropouts (fewer than
//   LOSS_CYCLES synchronized low cycles) are ignored in STABLE and RUN.
// -----------------------------------------------------------------------------
module ctrl_clken
    import ctrl_clken_pkg::*;
#(
    parameter int CH          = 3,
    parameter int CW          = 8,
    parameter int RST_CYCLES  = 16,
    parameter int LOSS_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_clken_if.slave  io_bus
);

    localparam int                SCNT_W    = f_scnt_w(RST_CYCLES);
    localparam logic [SCNT_W-1:0] SCNT_TERM = SCNT_W'(RST_CYCLES - 1);

    // Empty marker scope that only elaborates for out-of-range settings, so a
    // bad configuration is visible in the elaborated hierarchy.
    if ((CH < 1) || (CH > 8) || (RST_CYCLES < 1) || (LOSS_CYCLES < 2)) begin : g_param_range_violation
    end

    // ---------------------------------------------------------------- sync
    logic r_sync_meta;
    logic r_locked_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else begin
            r_sync_meta <= io_bus.locked_in;
            r_locked_s  <= r_sync_meta;
        end
    end

    // ---------------------------------------------------------------- state
    state_t            r_state;
    state_t            w_state_next;
    logic [SCNT_W-1:0] r_scnt;
    logic [SCNT_W-1:0] w_scnt_next;
    logic              w_loss;

    // ----------------------------------------------------- loss detection
    // Loss is taken from a register in both builds so that the FSM never sees
    // a combinational path from the synchronizer; this adds one edge of
    // latency on top of the two synchronizer stages.
`ifdef CTRL_CLKEN_LOCK_FILTER_EN
    localparam int               LOW_W   = f_low_w(LOSS_CYCLES);
    localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(LOSS_CYCLES);

    logic [LOW_W-1:0] r_lowcnt;

    // Saturating run length of low synchronized lock; only meaningful while
    // the FSM is watching for loss (STABLE/RUN).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lowcnt <= '0;
        end else if ((r_state == ST_WAIT_LOCK) || r_locked_s) begin
            r_lowcnt <= '0;
        end else if (r_lowcnt != LOW_MAX) begin
            r_lowcnt <= r_lowcnt + LOW_W'(1);
        end
    end

    assign w_loss = (r_lowcnt == LOW_MAX);
`else
    logic r_low;

    // Any single low synchronized cycle in STABLE/RUN is a loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_low <= 1'b0;
        end else begin
            r_low <= (r_state != ST_WAIT_LOCK) && !r_locked_s;
        end
    end

    assign w_loss = r_low;
`endif

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_LOCK;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_scnt  <= w_scnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_scnt_next  = r_scnt;
        unique case (r_state)
            ST_WAIT_LOCK: begin
                w_scnt_next = '0;
                if (r_locked_s) begin
                    w_state_next = ST_STABLE;
                end
            end
            ST_STABLE: begin
                // Loss is checked first so it wins over the terminal count.
                if (w_loss) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_scnt_next  = '0;
                end else if (r_scnt == SCNT_TERM) begin
                    w_state_next = ST_RUN;
                    w_scnt_next  = '0;
                end else begin
                    w_scnt_next  = r_scnt + SCNT_W'(1);
                end
            end
            ST_RUN: begin
                if (w_loss) begin
                    w_state_next = ST_WAIT_LOCK;
                end
            end
            default: begin
                w_state_next = ST_WAIT_LOCK;
                w_scnt_next  = '0;
            end
        endcase
    end

    // ---------------------------------------------------------- outputs
    // Registered from the next state so rst_out/ready change on the same edge
    // the state does.
    logic w_run_next;
    logic r_rst_out;
    logic r_ready;

    assign w_run_next = (w_state_next == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_rst_out <= !w_run_next;
            r_ready   <= w_run_next;
        end
    end

    // --------------------------------------------------------- dividers
    logic [CH-1:0] w_ce;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            ctrl_clken_div #(
                .CW (CW)
            ) u_div (
                .clk (clk),
                .rst (rst),
                .run (w_run_next),
                .div (io_bus.div[gi*CW +: CW]),
                .ce  (w_ce[gi])
            );
        end
    endgenerate

    assign io_bus.ce      = w_ce;
    assign io_bus.rst_out = r_rst_out;
    assign io_bus.ready   = r_ready;

endmodule

// File: tb/tb_ctrl_clken.sv
// -----------------------------------------------------------------------------
// tb_ctrl_clken
// Directed bench for ctrl_clken (CH=3, CW=8, RST_CYCLES=16, LOSS_CYCLES=4).
// Outputs are sampled 1 time unit after each rising edge; edge numbers in the
// comments count rising edges after the step that set up the stimulus.
// -----------------------------------------------------------------------------
module tb_ctrl_clken;

    localparam int CH          = 3;
    localparam int CW          = 8;
    localparam int RST_CYCLES  = 16;
    localparam int LOSS_CYCLES = 4;

    logic clk;
    logic rst;

    int total;
    int bad;

    ctrl_clken_if #(.CH(CH), .CW(CW)) u_if ();

    ctrl_clken #(
        .CH          (CH),
        .CW          (CW),
        .RST_CYCLES  (RST_CYCLES),
        .LOSS_CYCLES (LOSS_CYCLES)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] exp_ce;
        total = 0;
        bad   = 0;

        // ---------------- reset
        rst            = 1'b1;
        u_if.locked_in = 1'b0;
        u_if.div       = {8'd4, 8'd1, 8'd0};
        tick(3);
        chk("reset_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        chk("reset_ready",   {7'd0, u_if.ready},   8'd0);
        chk("reset_ce",      {5'd0, u_if.ce},      8'd0);

        // ---------------- release: lock high before edge 1
        rst            = 1'b0;
        u_if.locked_in = 1'b1;
        tick(18);
        chk("rel_e18_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        chk("rel_e18_ready",   {7'd0, u_if.ready},   8'd0);
        tick(1);
        chk("rel_e19_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        chk("rel_e19_ready",   {7'd0, u_if.ready},   8'd1);
        chk("run0_ce",         {5'd0, u_if.ce},      8'd7);

        // ---------------- divider patterns; div[2] 4->2 during RUN cycle 6
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            exp_ce[0] = 1'b1;
            exp_ce[1] = ((i % 2) == 0);
            exp_ce[2] = (i <= 10) ? ((i % 5) == 0) : (((i - 10) % 3) == 0);
            chk($sformatf("run%0d_ce", i), {5'd0, u_if.ce}, {5'd0, exp_ce});
            if (i == 6) begin
                u_if.div[23:16] = 8'd2;
            end
        end

        // ---------------- one-cycle lock dropout in RUN (low before edge k)
        u_if.locked_in = 1'b0;
        tick(1);
        u_if.locked_in = 1'b1;
        tick(2);
        chk("pulse_k2_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        tick(1);
`ifndef CTRL_CLKEN_LOCK_FILTER_EN
        chk("pulse_k3_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        chk("pulse_k3_ready",   {7'd0, u_if.ready},   8'd0);
        chk("pulse_k3_ce",      {5'd0, u_if.ce},      8'd0);
        tick(16);
        chk("pulse_k19_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        tick(1);
        chk("pulse_k20_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        chk("pulse_k20_ready",   {7'd0, u_if.ready},   8'd1);
        chk("pulse_k20_ce",      {5'd0, u_if.ce},      8'd7);
`else
        chk("pulse_k3_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        chk("pulse_k3_ready",   {7'd0, u_if.ready},   8'd1);
        tick(17);
        chk("pulse_k20_ready",  {7'd0, u_if.ready},   8'd1);

        // ---------------- three-cycle dropout ignored
        u_if.locked_in = 1'b0;
        tick(3);
        u_if.locked_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk($sformatf("drop3_%0d_rst_out", i), {7'd0, u_if.rst_out}, 8'd0);
        end

        // ---------------- four-cycle dropout: loss after edge k+6
        u_if.locked_in = 1'b0;
        tick(4);
        u_if.locked_in = 1'b1;
        tick(2);
        chk("drop4_k5_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        tick(1);
        chk("drop4_k6_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        chk("drop4_k6_ready",   {7'd0, u_if.ready},   8'd0);
        chk("drop4_k6_ce",      {5'd0, u_if.ce},      8'd0);
        tick(16);
        chk("drop4_k22_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        tick(1);
        chk("drop4_k23_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        chk("drop4_k23_ce",      {5'd0, u_if.ce},      8'd7);
`endif

        // ---------------- rst mid-RUN, then full re-sequence (div = {2,1,0})
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("srst_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        chk("srst_ready",   {7'd0, u_if.ready},   8'd0);
        chk("srst_ce",      {5'd0, u_if.ce},      8'd0);
        rst = 1'b0;
        tick(18);
        chk("reseq_e18_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        tick(1);
        chk("reseq_e19_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        chk("reseq_e19_ready",   {7'd0, u_if.ready},   8'd1);
        chk("reseq_run0_ce",     {5'd0, u_if.ce},      8'd7);
        tick(1);
        chk("reseq_run1_ce",     {5'd0, u_if.ce},      8'd1);
        tick(1);
        chk("reseq_run2_ce",     {5'd0, u_if.ce},      8'd3);
        tick(1);
        chk("reseq_run3_ce",     {5'd0, u_if.ce},      8'd5);

        // ---------------- dropout landing on the STABLE terminal count
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(15);
        u_if.locked_in = 1'b0;   // low before edge 16 only
        tick(1);
        u_if.locked_in = 1'b1;
        tick(2);
        chk("tc_e18_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        tick(1);
`ifndef CTRL_CLKEN_LOCK_FILTER_EN
        chk("tc_e19_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        chk("tc_e19_ready",   {7'd0, u_if.ready},   8'd0);
        tick(16);
        chk("tc_e35_rst_out", {7'd0, u_if.rst_out}, 8'd1);
        tick(1);
        chk("tc_e36_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        chk("tc_e36_ready",   {7'd0, u_if.ready},   8'd1);
`else
        chk("tc_e19_rst_out", {7'd0, u_if.rst_out}, 8'd0);
        chk("tc_e19_ready",   {7'd0, u_if.ready},   8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
